// File: rtl/elevator_call_queue.sv
// Floor-call front end: debounces KEY, latches calls, sweeps for the next target, offers it via valid/ready.
// Optional build macro CALL_CANCEL_EN: a repeat press on a pending, non-offered floor cancels that call.
module elevator_call_queue #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [2:0] cur_floor,
    input  logic       arrived,
    output logic [2:0] req_floor,
    output logic       req_valid,
    input  logic       req_ready,
    output logic [3:0] pending,
    output logic       dir_up
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OFFER, BUSY} state_t;

    state_t           state, state_next;
    logic [3:0]       sync1, sync2, deb, press;
    logic [CNT_W-1:0] cnt [4];
    logic             floor_ok;
    logic [1:0]       cur_idx;
    logic [3:0]       clr_mask, set_mask, cancel_mask, pending_next;
    logic             found_up, found_dn;
    logic [1:0]       up_idx, dn_idx;
    logic [2:0]       floor_next;
    logic             dir_next;
`ifdef CALL_CANCEL_EN
    logic [3:0]       offer_mask;
`endif

    function automatic logic [2:0] idx_to_floor(input logic [1:0] idx);
        return {1'b0, idx} + 3'd1;
    endfunction

    // Debounce: a level is accepted on the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
            deb   <= '1;
            press <= '0;
            for (int unsigned i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
            for (int unsigned i = 0; i < 4; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    cnt[i]   <= '0;
                    deb[i]   <= sync2[i];
                    press[i] <= ~sync2[i];
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        floor_ok = (cur_floor >= 3'd1) && (cur_floor <= 3'd4);
        cur_idx  = floor_ok ? 2'(cur_floor - 3'd1) : 2'd0;
        clr_mask = '0;
        if (arrived && floor_ok) clr_mask[cur_idx] = 1'b1;
`ifdef CALL_CANCEL_EN
        offer_mask = '0;
        if (state != IDLE) offer_mask[2'(req_floor - 3'd1)] = 1'b1;
        set_mask    = press & ~pending;
        cancel_mask = press & pending & ~offer_mask;
`else
        set_mask    = press;
        cancel_mask = '0;
`endif
        // Clear from arrival is applied last so it wins over a same-cycle press.
        pending_next = ((pending | set_mask) & ~cancel_mask) & ~clr_mask;
    end

    always_comb begin
        found_up = 1'b0;
        found_dn = 1'b0;
        up_idx   = '0;
        dn_idx   = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (pending[i] && (i > 32'(cur_idx)) && !found_up) begin
                found_up = 1'b1;
                up_idx   = 2'(i);
            end
            if (pending[i] && (i < 32'(cur_idx))) begin
                found_dn = 1'b1;
                dn_idx   = 2'(i);
            end
        end
    end

    always_comb begin
        state_next = state;
        floor_next = req_floor;
        dir_next   = dir_up;
        req_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_next = OFFER;
                    if (dir_up) begin
                        if (found_up) begin
                            floor_next = idx_to_floor(up_idx);
                        end else if (found_dn) begin
                            dir_next   = 1'b0;
                            floor_next = idx_to_floor(dn_idx);
                        end else begin
                            floor_next = idx_to_floor(cur_idx);
                        end
                    end else begin
                        if (found_dn) begin
                            floor_next = idx_to_floor(dn_idx);
                        end else if (found_up) begin
                            dir_next   = 1'b1;
                            floor_next = idx_to_floor(up_idx);
                        end else begin
                            floor_next = idx_to_floor(cur_idx);
                        end
                    end
                end
            end
            OFFER: begin
                req_valid = 1'b1;
                if (req_ready) state_next = BUSY;
            end
            BUSY: begin
                if (arrived) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state     <= IDLE;
            pending   <= '0;
            req_floor <= 3'd1;
            dir_up    <= 1'b1;
        end else begin
            state     <= state_next;
            pending   <= pending_next;
            req_floor <= floor_next;
            dir_up    <= dir_next;
        end
    end

endmodule

// File: tb/tb_elevator_call_queue.sv
// Self-checking bench for elevator_call_queue: sweep-order vector table plus hand-written corner sequences.
module tb_elevator_call_queue;

    logic       CLOCK_50;
    logic       reset;
    logic [3:0] KEY;
    logic [2:0] cur_floor;
    logic       arrived;
    logic [2:0] req_floor;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] pending;
    logic       dir_up;

    int unsigned errors   = 0;
    int unsigned checks   = 0;
    int unsigned hs_count = 0;
    logic [2:0]  sb [$];
    logic [2:0]  exp_f;

    typedef struct packed {
        logic [2:0]      cur;
        logic [3:0]      mask;
        logic [1:0]      n;
        logic [2:0][2:0] ord;
        logic [2:0]      dirs;
    } vec_t;

    vec_t vecs [6];

    elevator_call_queue #(.DEBOUNCE_CYCLES(4)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .KEY      (KEY),
        .cur_floor(cur_floor),
        .arrived  (arrived),
        .req_floor(req_floor),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .pending  (pending),
        .dir_up   (dir_up)
    );

    initial CLOCK_50 = 1'b0;
    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    // Offers are compared on the falling edge preceding the completing rising edge.
    always @(negedge CLOCK_50) begin
        if (!reset && req_valid && req_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL offer_unexpected: got floor %0d, required no offer", req_floor);
            end else begin
                exp_f = sb.pop_front();
                chk("offer_floor", 32'(req_floor), 32'(exp_f));
            end
            hs_count++;
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        KEY       = 4'hF;
        arrived   = 1'b0;
        req_ready = 1'b0;
        cur_floor = 3'd1;
        repeat (3) tick();
        reset = 1'b0;
        sb.delete();
    endtask

    task automatic press_keys(input logic [3:0] mask);
        KEY = ~mask;
        repeat (10) tick();
        KEY = 4'hF;
        repeat (10) tick();
    endtask

    task automatic arrive(input logic [2:0] f);
        cur_floor = f;
        arrived   = 1'b1;
        tick();
        arrived = 1'b0;
        tick();
    endtask

    task automatic wait_hs();
        int unsigned start = hs_count;
        bit          done  = 1'b0;
        req_ready = 1'b1;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            if (hs_count != start) done = 1'b1;
        end
        req_ready = 1'b0;
        chk("handshake_seen", 32'(done), 32'd1);
    endtask

    initial begin
        vec_t       v;
        logic [3:0] seen;

        vecs[0] = '{cur: 3'd1, mask: 4'b0100, n: 2'd1, ord: {3'd0, 3'd0, 3'd3}, dirs: 3'b001};
        vecs[1] = '{cur: 3'd2, mask: 4'b1101, n: 2'd3, ord: {3'd1, 3'd4, 3'd3}, dirs: 3'b011};
        vecs[2] = '{cur: 3'd4, mask: 4'b0011, n: 2'd2, ord: {3'd0, 3'd1, 3'd2}, dirs: 3'b000};
        vecs[3] = '{cur: 3'd3, mask: 4'b0100, n: 2'd1, ord: {3'd0, 3'd0, 3'd3}, dirs: 3'b001};
        vecs[4] = '{cur: 3'd0, mask: 4'b1000, n: 2'd1, ord: {3'd0, 3'd0, 3'd4}, dirs: 3'b001};
        vecs[5] = '{cur: 3'd3, mask: 4'b1011, n: 2'd3, ord: {3'd1, 3'd2, 3'd4}, dirs: 3'b001};

        // Reset state
        do_reset();
        chk("reset_pending", 32'(pending), 32'd0);
        chk("reset_valid", 32'(req_valid), 32'd0);
        chk("reset_floor", 32'(req_floor), 32'd1);
        chk("reset_dir", 32'(dir_up), 32'd1);

        // Bounce rejection on KEY[2]
        seen = '0;
        for (int c = 0; c < 20; c++) begin
            KEY[2] = 1'((c >> 1) & 1);
            tick();
            seen |= pending;
        end
        KEY[2] = 1'b1;
        repeat (10) begin
            tick();
            seen |= pending;
        end
        chk("bounce_pending", 32'(seen), 32'd0);
        chk("bounce_valid", 32'(req_valid), 32'd0);

        // Sweep vectors, each from reset with dir_up = 1
        for (int k = 0; k < 6; k++) begin
            v = vecs[k];
            do_reset();
            cur_floor = v.cur;
            press_keys(v.mask);
            chk("vec_pending", 32'(pending), 32'(v.mask));
            for (int j = 0; j < int'(v.n); j++) begin
                chk("vec_offer", 32'({req_valid, req_floor}), 32'({1'b1, v.ord[j]}));
                sb.push_back(v.ord[j]);
                wait_hs();
                chk("vec_dir", 32'(dir_up), 32'(v.dirs[j]));
                chk("vec_busy_valid", 32'(req_valid), 32'd0);
                arrive(v.ord[j]);
                chk("vec_cleared", 32'(pending[int'(v.ord[j]) - 1]), 32'd0);
            end
            chk("vec_done_pending", 32'(pending), 32'd0);
            tick();
            chk("vec_done_valid", 32'(req_valid), 32'd0);
        end

        // Press latency, backpressure, arrival in OFFER
        do_reset();
        KEY[1] = 1'b0;
        repeat (6) tick();
        chk("lat_before", 32'(pending), 32'd0);
        tick();
        chk("lat_pending", 32'(pending), 32'b0010);
        chk("lat_valid_low", 32'(req_valid), 32'd0);
        tick();
        chk("lat_offer", 32'({req_valid, req_floor}), 32'({1'b1, 3'd2}));
        repeat (2) tick();
        KEY[1] = 1'b1;
        for (int c = 0; c < 50; c++) begin
            if (c == 0)  KEY[3] = 1'b0;
            if (c == 10) KEY[3] = 1'b1;
            if (c == 30) begin
                cur_floor = 3'd2;
                arrived   = 1'b1;
            end
            if (c == 31) arrived = 1'b0;
            tick();
            chk("stall_offer", 32'({req_valid, req_floor}), 32'({1'b1, 3'd2}));
        end
        chk("stall_pending", 32'(pending), 32'b1000);
        sb.push_back(3'd2);
        wait_hs();
        chk("hs_valid_drop", 32'(req_valid), 32'd0);
        sb.push_back(3'd4);
        arrive(3'd2);
        chk("next_offer", 32'({req_valid, req_floor}), 32'({1'b1, 3'd4}));
        wait_hs();
        arrive(3'd4);
        chk("bp_done_pending", 32'(pending), 32'd0);

        // Press pulse and arrival hit floor 2 in the same cycle
        cur_floor = 3'd2;
        KEY[1] = 1'b0;
        repeat (6) tick();
        arrived = 1'b1;
        tick();
        arrived = 1'b0;
        chk("press_vs_clear", 32'(pending), 32'd0);
        repeat (3) tick();
        KEY[1] = 1'b1;
        repeat (10) tick();
        chk("press_vs_clear_idle", 32'({req_valid, pending}), 32'd0);

        // Repeat presses: ignored, or cancel for non-offered floors
        do_reset();
        press_keys(4'b0100);
        chk("rep_offer", 32'({req_valid, req_floor}), 32'({1'b1, 3'd3}));
        press_keys(4'b1000);
        chk("rep_second_call", 32'(pending), 32'b1100);
        press_keys(4'b1000);
`ifdef CALL_CANCEL_EN
        chk("rep_cancel", 32'(pending), 32'b0100);
`else
        chk("rep_ignored", 32'(pending), 32'b1100);
`endif
        press_keys(4'b0100);
`ifdef CALL_CANCEL_EN
        chk("rep_offered_kept", 32'(pending), 32'b0100);
`else
        chk("rep_offered_kept", 32'(pending), 32'b1100);
`endif
        chk("rep_offer_stands", 32'({req_valid, req_floor}), 32'({1'b1, 3'd3}));
        sb.push_back(3'd3);
        wait_hs();
`ifdef CALL_CANCEL_EN
        arrive(3'd3);
        chk("rep_end", 32'({req_valid, pending}), 32'd0);
`else
        sb.push_back(3'd4);
        arrive(3'd3);
        chk("rep_next_offer", 32'({req_valid, req_floor}), 32'({1'b1, 3'd4}));
        wait_hs();
        arrive(3'd4);
        chk("rep_end", 32'({req_valid, pending}), 32'd0);
`endif

        // Reset while an offer is outstanding
        do_reset();
        press_keys(4'b1000);
        chk("rst_offer", 32'({req_valid, req_floor}), 32'({1'b1, 3'd4}));
        reset = 1'b1;
        tick();
        chk("rst_valid", 32'(req_valid), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_floor", 32'(req_floor), 32'd1);
        reset = 1'b0;
        tick();

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
